yutorina_bus_arbiter: RTL
=========================

Name: yutorina_bus_arbiter

Overview:
- Shared-bus arbiter and master multiplexer directly downstream of yutorina_cpu.
- Consumes the CPU's instruction-side (i_*) and data-side (d_*) bus-master ports, plus optional extra masters (e.g. DMA).
- Grants exactly one master the shared bus using round-robin priority.
- Drives that master's address/strobe/rw/write-data onto the slave-side bus and routes ready back to it alone.

Parameters:
- NUM_MASTERS, 4, number of bus masters (2..8); CPU i-side = index 0, d-side = index 1.
- ADDR_W, 30, word address width (matches WordAddrBus).
- DATA_W, 32, data width (matches WordDataBus).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- m_req_  in  NUM_MASTERS  per-master bus request, active-low
- m_addr  in  NUM_MASTERS*ADDR_W  per-master address, master k at [k*ADDR_W +: ADDR_W]
- m_as_  in  NUM_MASTERS  per-master address strobe, active-low
- m_rw  in  NUM_MASTERS  per-master direction, 1=READ 0=WRITE
- m_w_data  in  NUM_MASTERS*DATA_W  per-master write data
- m_grnt_  out  NUM_MASTERS  per-master grant, active-low, at most one low
- m_rdy_  out  NUM_MASTERS  per-master ready, active-low; only owner's may be low
- m_r_data  out  DATA_W  read data, broadcast to all masters
- s_addr  out  ADDR_W  shared-bus address
- s_as_  out  1  shared-bus address strobe, active-low
- s_rw  out  1  shared-bus direction
- s_w_data  out  DATA_W  shared-bus write data
- s_rdy_  in  1  shared-bus ready from addressed slave, active-low
- s_r_data  in  DATA_W  shared-bus read data

Behaviour:
- State: owner index (log2 NUM_MASTERS bits), owner_valid flag, m_grnt_ register. States: IDLE (no owner) and OWNED(k).
- Reset (rst low, async): owner=NUM_MASTERS-1, owner_valid=0, m_grnt_ all 1. Combinational outputs then read: s_as_=1, s_rw=1, s_addr=0, s_w_data=0, m_rdy_ all 1, m_r_data=s_r_data.
- Arbitration is evaluated each rising edge:
  - IDLE, any m_req_ low: grant the first requesting index searching owner+1, owner+2, ... modulo NUM_MASTERS. Set owner and owner_valid; that m_grnt_ bit goes low in the next cycle (1-cycle req->grant latency).
  - IDLE, no requests: stay IDLE.
  - OWNED(k), m_req_[k] low: hold grant regardless of other requests (bus lock; no preemption).
  - OWNED(k), m_req_[k] high: release at this edge. If any other master (or k itself) requests, grant the next in round-robin order after k at the same edge (zero dead cycles). Otherwise go IDLE with all grnt_ high.
- Round-robin pointer is the last owner. A releasing master is searched last, so the master that just released is never re-granted while another master requests.
- Mux (combinational from registered owner):
  - When owner_valid: s_addr, s_as_, s_rw, s_w_data = master[owner]'s signals; m_rdy_[owner]=s_rdy_; all other m_rdy_=1.
  - When IDLE: reset values above.
- Simultaneous requests from all masters are served in strict rotation: owner+1 first.
- A request withdrawn before grant is simply dropped; no memory of pending requests.
- s_rdy_ while IDLE is ignored.
- Reset mid-transfer: grant and strobe drop immediately (async), with no wait for s_rdy_.
- Owner index wrap: NUM_MASTERS-1 -> 0.
- Protocol rule on masters: hold m_req_ low until the final s_rdy_ of the access is seen. This is checked by assertion in the bench, not enforced by the arbiter.

Decomposition:
- Shared package/header (bus.h): BUS_OWNER widths, `READ/`WRITE encodings, `ENABLE_/`DISABLE_ active-low constants, MasterIdxBus width macro. Reuse the existing WordAddrBus/WordDataBus.
- One natural sub-module: yutorina_rr_pick. It is combinational and takes request vector + last owner, returning a found flag and the next index. Everything else (owner register, mux, rdy routing) stays in the top.

Test Plan:
- Reset then m_req_=4'b1110 -> at the second edge m_grnt_=4'b1110; s_addr follows m_addr[0] (e.g. 0x0000_1000); s_as_ follows m_as_[0].
- Master 0 owns the bus, s_rdy_ pulses low with s_r_data=0xDEADBEEF -> m_rdy_=4'b1110, m_r_data=0xDEADBEEF; m_rdy_[1..3] stay 1.
- All four request continuously, each releases after 3 cycles -> grant order 0,1,2,3,0 with no idle cycle between owners.
- Owner 2 releases while only master 2 requests again next cycle -> one IDLE cycle (grnt_=4'b1111, s_as_=1), then re-grant to 2.
- Master 1 asserts req_ for 1 cycle while master 0 owns, then withdraws -> master 1 never granted; bus goes IDLE after master 0 releases.
- rst driven low mid-access while master 3 owns -> m_grnt_=4'b1111 and s_as_=1 asynchronously. After reset release, the first grant with all requesting goes to master 0.

Source files
------------

// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared bus constants for the yutorina arbiter: word widths, active-low
// enable levels, read/write encoding and the arbiter state type.
package yutorina_bus_arbiter_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic RW_READ  = 1'b1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/yutorina_rr_pick.sv
// Round-robin search: first active request after last_i, wrapping, with
// last_i itself considered last.
module yutorina_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset to the nearest so the nearest match wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = last_i;
        cand    = last_i;
        for (int off = N; off >= 1; off--) begin
            cand = IDX_W'((int'(last_i) + off) % N);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Round-robin shared-bus arbiter with bus lock: grants one master, muxes its
// request signals onto the slave bus and routes ready back to it alone.
module yutorina_bus_arbiter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = WORD_ADDR_W,
    parameter int DATA_W      = WORD_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req_,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_as_,
    input  logic [NUM_MASTERS-1:0]        m_rw,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_w_data,
    output logic [NUM_MASTERS-1:0]        m_grnt_,
    output logic [NUM_MASTERS-1:0]        m_rdy_,
    output logic [DATA_W-1:0]             m_r_data,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_as_,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_w_data,
    input  logic                          s_rdy_,
    input  logic [DATA_W-1:0]             s_r_data
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [NUM_MASTERS-1:0] grnt_q, grnt_d;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;

    logic [ADDR_W-1:0]      addr_arr  [NUM_MASTERS];
    logic [DATA_W-1:0]      wdata_arr [NUM_MASTERS];

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_split
        assign addr_arr[k]  = m_addr[k*ADDR_W +: ADDR_W];
        assign wdata_arr[k] = m_w_data[k*DATA_W +: DATA_W];
    end

    yutorina_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (~m_req_),
        .last_i  (owner_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= IDX_W'(NUM_MASTERS - 1);
            grnt_q  <= '1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grnt_q  <= grnt_d;
        end
    end

    // The owner keeps the bus while its request stays low; on release the
    // next requester is granted at the same edge.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grnt_d  = grnt_q;
        if (state_q == ARB_IDLE || m_req_[owner_q] == DISABLE_) begin
            grnt_d = '1;
            if (pick_found) begin
                state_d          = ARB_OWNED;
                owner_d          = pick_idx;
                grnt_d[pick_idx] = ENABLE_;
            end else begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_comb begin
        s_addr   = '0;
        s_as_    = DISABLE_;
        s_rw     = RW_READ;
        s_w_data = '0;
        m_rdy_   = '1;
        if (state_q == ARB_OWNED) begin
            s_addr          = addr_arr[owner_q];
            s_as_           = m_as_[owner_q];
            s_rw            = m_rw[owner_q];
            s_w_data        = wdata_arr[owner_q];
            m_rdy_[owner_q] = s_rdy_;
        end
    end

    assign m_grnt_  = grnt_q;
    assign m_r_data = s_r_data;

endmodule
